// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register bank with synchronised pins, atomic write commit and CIPO read-back.
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_LENGTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic                         frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 2);

    typedef enum logic [1:0] {IDLE, CMD, DATA, OVF} state_t;

    logic [SYNC_LENGTH-1:0]     sclk_s_q, copi_s_q, ncs_s_q;
    logic                       sclk_e_q, copi_e_q, ncs_e_q;
    logic                       sclk_rise_q, sclk_fall_q, ncs_rise_q, ncs_fall_q;
    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [FRAME_LEN-1:0]       sr_q, sr_d;
    logic [DATA_W-1:0]          osr_q, rd_d;
    logic                       rd_q, cipo_q, cipo_oe_q, frame_err_q;
    logic [NUM_REGS-1:0]        wr_pulse_q;
    logic [NUM_REGS*DATA_W-1:0] regs_q;
    logic [ADDR_W-1:0]          addr_end;
    logic                       addr_ok;

    // Edge strobes are registered so every pin event reaches the FSM SYNC_LENGTH+1 cycles late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s_q <= '0;
            copi_s_q <= '1;
            ncs_s_q  <= '1;
            {sclk_e_q, copi_e_q, ncs_e_q} <= 3'b011;
            {sclk_rise_q, sclk_fall_q, ncs_rise_q, ncs_fall_q} <= '0;
        end else begin
            sclk_s_q    <= {sclk_s_q[SYNC_LENGTH-2:0], sclk};
            copi_s_q    <= {copi_s_q[SYNC_LENGTH-2:0], copi};
            ncs_s_q     <= {ncs_s_q[SYNC_LENGTH-2:0], ncs};
            sclk_e_q    <= sclk_s_q[SYNC_LENGTH-1];
            copi_e_q    <= copi_s_q[SYNC_LENGTH-1];
            ncs_e_q     <= ncs_s_q[SYNC_LENGTH-1];
            sclk_rise_q <= sclk_s_q[SYNC_LENGTH-1] & ~sclk_e_q;
            sclk_fall_q <= ~sclk_s_q[SYNC_LENGTH-1] & sclk_e_q;
            ncs_rise_q  <= ncs_s_q[SYNC_LENGTH-1] & ~ncs_e_q;
            ncs_fall_q  <= ~ncs_s_q[SYNC_LENGTH-1] & ncs_e_q;
        end
    end

    assign sr_d     = {sr_q[FRAME_LEN-2:0], copi_e_q};
    assign addr_end = sr_q[FRAME_LEN-2 -: ADDR_W];
    assign addr_ok  = {1'b0, addr_end} < (ADDR_W+1)'(NUM_REGS);

    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (sr_d[ADDR_W-1:0] == ADDR_W'(k)) rd_d = regs_q[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            osr_q       <= '0;
            rd_q        <= 1'b0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            wr_pulse_q  <= '0;
            frame_err_q <= 1'b0;
            regs_q      <= '0;
        end else begin
            wr_pulse_q  <= '0;
            frame_err_q <= 1'b0;
            if (ncs_rise_q) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                rd_q      <= 1'b0;
                cipo_q    <= 1'b0;
                cipo_oe_q <= 1'b0;
                if (cnt_q != '0) begin
                    if (cnt_q == CW'(FRAME_LEN) && addr_ok) begin
                        for (int k = 0; k < NUM_REGS; k++)
                            if (sr_q[FRAME_LEN-1] && addr_end == ADDR_W'(k)) begin
                                regs_q[k*DATA_W +: DATA_W] <= sr_q[DATA_W-1:0];
                                wr_pulse_q[k]              <= 1'b1;
                            end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
            end else if (ncs_fall_q) begin
                state_q <= CMD;
                cnt_q   <= '0;
                sr_q    <= '0;
            end else if (state_q != IDLE) begin
                if (sclk_rise_q) begin
                    sr_q <= sr_d;
                    if (cnt_q != CW'(FRAME_LEN + 1)) cnt_q <= cnt_q + 1'b1;
                    if (state_q == CMD && cnt_q == CW'(ADDR_W)) begin
                        state_q   <= DATA;
                        rd_q      <= ~sr_d[ADDR_W];
                        cipo_oe_q <= ~sr_d[ADDR_W];
                        osr_q     <= rd_d;
                    end
                    if (state_q == DATA && cnt_q == CW'(FRAME_LEN)) state_q <= OVF;
                end
                if (sclk_fall_q && rd_q && (state_q == DATA || state_q == OVF)) begin
                    cipo_q <= osr_q[DATA_W-1];
                    osr_q  <= {osr_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign regs      = regs_q;
    assign wr_pulse  = wr_pulse_q;
    assign frame_err = frame_err_q;
    assign cipo      = cipo_q;
    assign cipo_oe   = cipo_oe_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized SPI frames against a register-array model with a queue-based scoreboard.
module tb_spi_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n, sclk, copi, ncs;
    logic        cipo, cipo_oe, frame_err;
    logic [39:0] regs;
    logic [4:0]  wr_pulse;

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_pulse(wr_pulse), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wr;
        logic        err;
        logic [39:0] regs;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mregs [5];
    ev_t        ev_q [$];
    logic [7:0] rd_exp [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] flat();
        logic [39:0] f;
        for (int k = 0; k < 5; k++) f[k*8 +: 8] = mregs[k];
        return f;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame outcome from the protocol rules: only a 16-bit frame to an existing register is valid.
    task automatic model(input logic [16:0] bits, input int n);
        ev_t        e;
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;
        rw    = bits[15];
        a     = bits[14:8];
        d     = bits[7:0];
        e.wr  = '0;
        e.err = 1'b0;
        if (n == 16 && a < 5) begin
            if (rw) begin
                mregs[a] = d;
                e.wr     = 5'(1 << a);
            end else rd_exp.push_back(mregs[a]);
        end else begin
            e.err = 1'b1;
            if (n == 16 && !rw) rd_exp.push_back(8'h00);
        end
        e.regs = flat();
        if (e.wr != 0 || e.err) ev_q.push_back(e);
    endtask

    task automatic frame(input logic [16:0] bits, input int n, input bit close);
        if (close) model(bits, n);
        ncs = 1'b0;
        clks(8);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            clks(8);
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
        if (close) begin
            clks(8);
            ncs = 1'b1;
            clks(14);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_pulse !== 5'b0 || frame_err !== 1'b0)) begin
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse wr_pulse=%b frame_err=%b expected none", wr_pulse, frame_err);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                check("wr_pulse", 64'(wr_pulse), 64'(e.wr));
                check("frame_err", 64'(frame_err), 64'(e.err));
                check("regs_at_commit", 64'(regs), 64'(e.regs));
            end
        end
    end

    initial begin : spi_mon
        int         idx;
        logic       rwb;
        logic [7:0] got;
        forever begin
            @(negedge ncs);
            idx = 0;
            rwb = 1'b1;
            got = '0;
            while (ncs == 1'b0) begin
                @(posedge sclk or posedge ncs);
                if (ncs == 1'b0) begin
                    if (idx == 0) rwb = copi;
                    check("cipo_oe", 64'(cipo_oe), 64'(idx >= 8 && !rwb));
                    if (idx < 8 || rwb || idx >= 16) check("cipo_idle", 64'(cipo), 64'(0));
                    if (idx >= 8 && idx < 16) got = {got[6:0], cipo};
                    idx++;
                end
            end
            if (idx == 16 && !rwb) begin
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected got=%0h expected none", got);
                end else check("read_data", 64'(got), 64'(rd_exp.pop_front()));
            end
        end
    end

    initial begin
        logic [15:0] f;
        int          r;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        for (int k = 0; k < 5; k++) mregs[k] = '0;
        clks(5);
        rst_n = 1'b1;
        clks(3);
        check("reset_regs", 64'(regs), 64'(0));
        check("reset_wr_pulse", 64'(wr_pulse), 64'(0));
        check("reset_frame_err", 64'(frame_err), 64'(0));
        check("reset_cipo", 64'(cipo), 64'(0));
        check("reset_cipo_oe", 64'(cipo_oe), 64'(0));

        frame({1'b0, 1'b1, 7'd4, 8'hA5}, 16, 1);
        check("write_a5_reg4", 64'(regs[39:32]), 64'(8'hA5));
        frame({1'b0, 1'b0, 7'd4, 8'h00}, 16, 1);
        check("read_keeps_regs", 64'(regs), 64'(flat()));

        frame(17'(16'h80FF >> 1), 15, 1);
        frame({16'h80FF, 1'b1}, 17, 1);
        check("short_long_regs", 64'(regs), 64'(flat()));

        frame({1'b0, 1'b1, 7'h20, 8'h3C}, 16, 1);
        frame({1'b0, 1'b0, 7'h20, 8'h00}, 16, 1);

        copi = 1'b1;
        repeat (20) begin
            sclk = 1'b1;
            clks(6);
            sclk = 1'b0;
            clks(6);
        end
        frame({1'b0, 1'b1, 7'd1, 8'h11}, 16, 1);
        check("noise_then_write", 64'(regs), 64'(flat()));

        frame(17'({1'b1, 7'd2, 8'h5A} >> 6), 10, 0);
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        clks(3);
        for (int k = 0; k < 5; k++) mregs[k] = '0;
        check("midframe_reset_regs", 64'(regs), 64'(0));
        rst_n = 1'b1;
        clks(12);
        check("post_reset_regs", 64'(regs), 64'(0));
        frame({1'b0, 1'b1, 7'd2, 8'h5A}, 16, 1);
        check("write_5a_reg2", 64'(regs[23:16]), 64'(8'h5A));

        repeat (24) begin
            f = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            r = $urandom_range(0, 9);
            if (r == 0) frame(17'(f >> 1), 15, 1);
            else if (r == 1) frame({f, 1'($urandom_range(0, 1))}, 17, 1);
            else frame({1'b0, f}, 16, 1);
        end

        clks(30);
        check("events_drained", 64'(ev_q.size()), 64'(0));
        check("reads_drained", 64'(rd_exp.size()), 64'(0));
        check("final_regs", 64'(regs), 64'(flat()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
